dma_apb_engine: RTL and testbench

- Single-channel byte-granular DMA controller with an APB slave configuration port and two single-port SRAM master ports (mem0, mem1).
- Software programs source, destination and size, then writes MODE=1; the engine copies SIZE bytes, clears MODE and raises INTR.
- Sits between the system APB bus and two word-wide synchronous SRAMs.

---
 rtl/dma_apb_engine.sv | 248 ++++++++++++++++++++++++
 tb/tb_dma_apb_engine.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dma_apb_engine.sv
// Single-channel byte-granular DMA engine: APB register slave plus two word-wide SRAM masters.
// Optional compare pass (MODE=2) and led result port are compiled in with DMA_VERIFY_EN.
module dma_apb_engine #(
  parameter int REG_ADDR_WIDTH = 32,
  parameter int REG_DATA_WIDTH = 32,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int MEM_DATA_WIDTH = 32,
  parameter int MEM_STRB_WIDTH = 4
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  output logic                      INTR,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic                      PREADY,
  input  logic                      PWRITE,
  input  logic [REG_ADDR_WIDTH-1:0] PADDR,
  input  logic [REG_DATA_WIDTH-1:0] PWDATA,
  output logic [REG_DATA_WIDTH-1:0] PRDATA,
  output logic                      mem0_en,
  output logic [MEM_STRB_WIDTH-1:0] mem0_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem0_addr,
  output logic [MEM_DATA_WIDTH-1:0] mem0_wdata,
  input  logic [MEM_DATA_WIDTH-1:0] mem0_rdata,
  output logic                      mem1_en,
  output logic [MEM_STRB_WIDTH-1:0] mem1_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem1_addr,
  output logic [MEM_DATA_WIDTH-1:0] mem1_wdata,
  input  logic [MEM_DATA_WIDTH-1:0] mem1_rdata
`ifdef DMA_VERIFY_EN
  ,
  output logic [1:0]                led
`endif
);

  localparam int BA_W = MEM_ADDR_WIDTH + 2;

  typedef enum logic [3:0] {
    S_IDLE, S_RD, S_RDW, S_WR, S_DONE,
    S_VRS, S_VWS, S_VRD, S_VWD, S_VCMP, S_VEND
  } state_t;

  state_t state_q, state_d;

  logic [REG_DATA_WIDTH-1:0] src_q, dest_q, size_q, mode_q, int_q, int_d;
  logic [REG_DATA_WIDTH-1:0] rem_q, rd_val;
  logic [BA_W-1:0]           src_cnt_q, dst_cnt_q;
  logic                      src_sel_q, dst_sel_q, err_q;
  logic [7:0]                sbyte_p1;

  logic                      apb_wr, regions_ok;
  logic [2:0]                reg_idx;
  logic                      load_copy, load_verify, start_err;

  logic                      acc_en, acc_sel;
  logic [MEM_STRB_WIDTH-1:0] acc_we;
  logic [MEM_ADDR_WIDTH-1:0] acc_addr;
  logic [MEM_DATA_WIDTH-1:0] acc_wdata;

  logic                      unused_paddr;

`ifdef DMA_VERIFY_EN
  logic [7:0]                dbyte_p1;
  logic                      mis_q;
`endif

  function automatic logic region_valid(input logic [3:0] r);
    region_valid = (r == 4'd1) || (r == 4'd2);
  endfunction

  function automatic logic [7:0] lane_byte(input logic [MEM_DATA_WIDTH-1:0] w,
                                           input logic [1:0] lane);
    lane_byte = w[{lane, 3'b000} +: 8];
  endfunction

  assign apb_wr       = PSEL && PENABLE && PWRITE;
  assign reg_idx      = PADDR[4:2];
  assign regions_ok   = region_valid(src_q[23:20]) && region_valid(dest_q[23:20]);
  assign PREADY       = 1'b1;
  assign INTR         = int_q[0];
  assign unused_paddr = ^{PADDR[REG_ADDR_WIDTH-1:5], PADDR[1:0]};

  always_comb begin
    rd_val = '0;
    case (reg_idx)
      3'd0:    rd_val = src_q;
      3'd1:    rd_val = dest_q;
      3'd2:    rd_val = size_q;
      3'd3:    rd_val = mode_q;
      3'd4:    rd_val = int_q;
      default: rd_val = '0;
    endcase
    PRDATA = (PSEL && !PWRITE) ? rd_val : '0;
  end

  // Start is taken from the stored MODE value one cycle after the APB write.
  always_comb begin
    state_d     = state_q;
    load_copy   = 1'b0;
    load_verify = 1'b0;
    start_err   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mode_q == REG_DATA_WIDTH'(1)) begin
          load_copy = 1'b1;
          if (!regions_ok) begin
            start_err = 1'b1;
            state_d   = S_DONE;
          end else if (size_q == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RD;
          end
        end
`ifdef DMA_VERIFY_EN
        else if (mode_q == REG_DATA_WIDTH'(2)) begin
          load_verify = 1'b1;
          state_d     = (!regions_ok || size_q == '0) ? S_VEND : S_VRS;
        end
`endif
      end
      S_RD:   state_d = S_RDW;
      S_RDW:  state_d = S_WR;
      S_WR:   state_d = (rem_q == REG_DATA_WIDTH'(1)) ? S_DONE : S_RD;
      S_DONE: state_d = S_IDLE;
`ifdef DMA_VERIFY_EN
      S_VRS:  state_d = S_VWS;
      S_VWS:  state_d = S_VRD;
      S_VRD:  state_d = S_VWD;
      S_VWD:  state_d = S_VCMP;
      S_VCMP: state_d = (rem_q == REG_DATA_WIDTH'(1)) ? S_VEND : S_VRS;
      S_VEND: state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase

    int_d = int_q;
    if (apb_wr && reg_idx == 3'd4) int_d = PWDATA;
    if (state_q == S_DONE) begin
      int_d[0] = 1'b1;
      if (err_q) int_d[1] = 1'b1;
    end
  end

  always_comb begin
    acc_en    = 1'b0;
    acc_sel   = 1'b0;
    acc_we    = '0;
    acc_addr  = '0;
    acc_wdata = '0;
    case (state_q)
      S_RD, S_VRS: begin
        acc_en   = 1'b1;
        acc_sel  = src_sel_q;
        acc_addr = src_cnt_q[BA_W-1:2];
      end
      S_VRD: begin
        acc_en   = 1'b1;
        acc_sel  = dst_sel_q;
        acc_addr = dst_cnt_q[BA_W-1:2];
      end
      S_WR: begin
        acc_en    = 1'b1;
        acc_sel   = dst_sel_q;
        acc_addr  = dst_cnt_q[BA_W-1:2];
        acc_we    = {{(MEM_STRB_WIDTH-1){1'b0}}, 1'b1} << dst_cnt_q[1:0];
        acc_wdata = {MEM_STRB_WIDTH{sbyte_p1}};
      end
      default: ;
    endcase

    mem0_en    = acc_en && !acc_sel;
    mem0_we    = mem0_en ? acc_we : '0;
    mem0_addr  = mem0_en ? acc_addr : '0;
    mem0_wdata = mem0_en ? acc_wdata : '0;
    mem1_en    = acc_en && acc_sel;
    mem1_we    = mem1_en ? acc_we : '0;
    mem1_addr  = mem1_en ? acc_addr : '0;
    mem1_wdata = mem1_en ? acc_wdata : '0;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dest_q    <= '0;
      size_q    <= '0;
      mode_q    <= '0;
      int_q     <= '0;
      rem_q     <= '0;
      src_cnt_q <= '0;
      dst_cnt_q <= '0;
      src_sel_q <= 1'b0;
      dst_sel_q <= 1'b0;
      err_q     <= 1'b0;
`ifdef DMA_VERIFY_EN
      mis_q     <= 1'b0;
      led       <= 2'b00;
`endif
    end else begin
      state_q <= state_d;
      int_q   <= int_d;
      if (apb_wr) begin
        case (reg_idx)
          3'd0: src_q  <= PWDATA;
          3'd1: dest_q <= PWDATA;
          3'd2: size_q <= PWDATA;
          3'd3: if (state_q == S_IDLE) mode_q <= PWDATA;
          default: ;
        endcase
      end
      if (load_copy || load_verify) begin
        src_cnt_q <= src_q[BA_W-1:0];
        dst_cnt_q <= dest_q[BA_W-1:0];
        rem_q     <= size_q;
        src_sel_q <= (src_q[23:20] == 4'd2);
        dst_sel_q <= (dest_q[23:20] == 4'd2);
        err_q     <= start_err;
      end
      if (state_q == S_WR || state_q == S_VCMP) begin
        src_cnt_q <= src_cnt_q + BA_W'(1);
        dst_cnt_q <= dst_cnt_q + BA_W'(1);
        rem_q     <= rem_q - REG_DATA_WIDTH'(1);
      end
      if (state_q == S_DONE) mode_q <= '0;
`ifdef DMA_VERIFY_EN
      if (load_copy || load_verify) led <= 2'b00;
      if (load_verify) mis_q <= !regions_ok;
      if (state_q == S_VCMP && sbyte_p1 != dbyte_p1) mis_q <= 1'b1;
      if (state_q == S_VEND) begin
        mode_q <= '0;
        led    <= mis_q ? 2'b01 : 2'b10;
      end
`endif
    end
  end

  // Read-data capture stage: byte lane picked while the SRAM output is valid.
  always_ff @(posedge CLK) begin
    if (state_q == S_RDW || state_q == S_VWS)
      sbyte_p1 <= lane_byte(src_sel_q ? mem1_rdata : mem0_rdata, src_cnt_q[1:0]);
`ifdef DMA_VERIFY_EN
    if (state_q == S_VWD)
      dbyte_p1 <= lane_byte(dst_sel_q ? mem1_rdata : mem0_rdata, dst_cnt_q[1:0]);
`endif
  end

endmodule

// File: tb/tb_dma_apb_engine.sv
// Self-checking bench for dma_apb_engine: SRAM models, APB driver and a write scoreboard.
module tb_dma_apb_engine;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        INTR, PSEL, PENABLE, PREADY, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        mem0_en, mem1_en;
  logic [3:0]  mem0_we, mem1_we;
  logic [9:0]  mem0_addr, mem1_addr;
  logic [31:0] mem0_wdata, mem1_wdata, mem0_rdata, mem1_rdata;
`ifdef DMA_VERIFY_EN
  logic [1:0]  led;
`endif

  dma_apb_engine dut (
    .CLK(CLK), .RSTN(RSTN), .INTR(INTR),
    .PSEL(PSEL), .PENABLE(PENABLE), .PREADY(PREADY), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .mem0_en(mem0_en), .mem0_we(mem0_we), .mem0_addr(mem0_addr),
    .mem0_wdata(mem0_wdata), .mem0_rdata(mem0_rdata),
    .mem1_en(mem1_en), .mem1_we(mem1_we), .mem1_addr(mem1_addr),
    .mem1_wdata(mem1_wdata), .mem1_rdata(mem1_rdata)
`ifdef DMA_VERIFY_EN
    , .led(led)
`endif
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int en_cnt = 0;

  logic [31:0] m0 [1024];
  logic [31:0] m1 [1024];
  logic [31:0] m1_init [1024];
  logic [46:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int lane);
    byte_of = 8'(w >> (lane * 8));
  endfunction

  // SRAM models: one-cycle read latency, byte write enables
  always @(posedge CLK) begin
    if (mem0_en) begin
      if (mem0_we == 4'b0) mem0_rdata <= m0[mem0_addr];
      for (int b = 0; b < 4; b++)
        if (mem0_we[b]) m0[mem0_addr][b*8 +: 8] <= mem0_wdata[b*8 +: 8];
    end
    if (mem1_en) begin
      if (mem1_we == 4'b0) mem1_rdata <= m1[mem1_addr];
      for (int b = 0; b < 4; b++)
        if (mem1_we[b]) m1[mem1_addr][b*8 +: 8] <= mem1_wdata[b*8 +: 8];
    end
  end

  task automatic sb_compare(input logic [46:0] got);
    if (exp_q.size() == 0) chk("wr_unexpected", got, 47'h0);
    else chk("wr", got, exp_q.pop_front());
  endtask

  always @(negedge CLK) begin
    if (RSTN) begin
      if (mem0_en || mem1_en) en_cnt++;
      if (mem0_en && mem0_we != 4'b0) sb_compare({1'b0, mem0_addr, mem0_we, mem0_wdata});
      if (mem1_en && mem1_we != 4'b0) sb_compare({1'b1, mem1_addr, mem1_we, mem1_wdata});
    end
  end

  // Expected writes for a mem0 -> mem1 copy, computed from the source image
  task automatic push_copy(input int src, input int dst, input int n);
    logic [7:0]  b;
    logic [9:0]  wa;
    logic [3:0]  we;
    for (int i = 0; i < n; i++) begin
      b  = byte_of(m0[((src + i) >> 2) & 1023], (src + i) & 3);
      wa = 10'(((dst + i) >> 2) & 1023);
      we = 4'(1 << ((dst + i) & 3));
      exp_q.push_back({1'b1, wa, we, {4{b}}});
    end
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge CLK); #1;
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = d;
    @(posedge CLK); #1;
    PENABLE = 1'b1;
    @(posedge CLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    @(posedge CLK); #1;
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
    #1 d = PRDATA;
    @(posedge CLK); #1;
    PENABLE = 1'b1;
    @(posedge CLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wait_intr(output int n);
    n = 0;
    while (!INTR && n < 300) begin
      @(posedge CLK); #1;
      n++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int n, en0;
    logic [7:0] eb;

    RSTN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0;
    mem0_rdata = '0; mem1_rdata = '0;
    for (int w = 0; w < 1024; w++) begin
      m0[w] = $urandom;
      m1[w] = $urandom;
      m1_init[w] = m1[w];
    end
    #2;
    chk("rst_pready", PREADY, 1'b1);
    chk("rst_intr", INTR, 1'b0);
    chk("rst_en", {mem0_en, mem1_en}, 2'b00);
    PSEL = 1'b1;
    #1 chk("rst_prdata", PRDATA, 32'h0);
    PSEL = 1'b0;
    #20 RSTN = 1'b1;

    // Register read/write
    for (int i = 0; i < 5; i++) apb_write(32'(i * 4), 32'(i));
    for (int i = 0; i < 5; i++) begin
      apb_read(32'(i * 4), rd);
      chk($sformatf("reg%0d", i), rd, 32'(i));
    end
    apb_read(32'h14, rd);
    chk("unmapped", rd, 32'h0);
    chk("rw_intr", INTR, 1'b0);
    chk("rw_no_access", en_cnt, 0);

    // Normal copy mem0 0x03.. -> mem1 0x14.., 11 bytes
    apb_write(32'h10, 32'h0);
    apb_write(32'h00, 32'h0010_0003);
    apb_write(32'h04, 32'h0020_0014);
    apb_write(32'h08, 32'd11);
    apb_write(32'h0C, 32'd0);
    push_copy(3, 32'h14, 11);
    apb_write(32'h0C, 32'd1);
    wait_intr(n);
    chk("copy_latency", n, 35);
    apb_read(32'h0C, rd);
    chk("copy_mode", rd, 32'h0);
    apb_read(32'h10, rd);
    chk("copy_int", rd, 32'h1);
    chk("copy_sb_empty", exp_q.size(), 0);
    for (int a = 32'h10; a < 32'h24; a++) begin
      if (a >= 32'h14 && a <= 32'h1E) eb = byte_of(m0[(a - 32'h14 + 3) >> 2], (a - 32'h14 + 3) & 3);
      else eb = byte_of(m1_init[a >> 2], a & 3);
      chk($sformatf("mem1_b%0h", a), byte_of(m1[a >> 2], a & 3), eb);
    end

    // Interrupt clear
    apb_write(32'h10, 32'h0);
    chk("intr_clear", INTR, 1'b0);

    // SIZE = 0
    apb_write(32'h08, 32'd0);
    en0 = en_cnt;
    apb_write(32'h0C, 32'd1);
    wait_intr(n);
    chk("size0_latency", n, 2);
    chk("size0_no_access", en_cnt, en0);
    apb_write(32'h10, 32'h0);

    // Bad source region
    apb_write(32'h00, 32'h0030_0000);
    en0 = en_cnt;
    apb_write(32'h0C, 32'd1);
    wait_intr(n);
    chk("bad_done", INTR, 1'b1);
    apb_read(32'h10, rd);
    chk("bad_int", rd, 32'h3);
    chk("bad_no_access", en_cnt, en0);
    apb_write(32'h10, 32'h0);

    // Async reset mid-copy
    apb_write(32'h00, 32'h0010_0000);
    apb_write(32'h04, 32'h0020_0100);
    apb_write(32'h08, 32'd20);
    push_copy(0, 32'h100, 20);
    apb_write(32'h0C, 32'd1);
    repeat (13) @(posedge CLK);
    #2;
    chk("mid_en_before", mem0_en, 1'b1);
    RSTN = 1'b0;
    #1;
    chk("mid_en_after", {mem0_en, mem1_en}, 2'b00);
    chk("mid_intr", INTR, 1'b0);
    exp_q.delete();
    #13 RSTN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      apb_read(32'(i * 4), rd);
      chk($sformatf("post_rst_reg%0d", i), rd, 32'h0);
    end
    repeat (5) @(posedge CLK);
    #1 chk("post_rst_idle", {mem0_en, mem1_en, INTR}, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
